// File: rtl/layer3_input_packer_pkg.sv
// Shared definitions for the layer-3 input packer: default geometry and FSM encoding.
package layer3_input_packer_pkg;

  localparam int DW_DEF     = 16;
  localparam int N_ELEM_DEF = 32;
  localparam int FLAT_W     = N_ELEM_DEF * DW_DEF;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_FIRE      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/layer3_input_packer_leaky_relu_act.sv
// Combinational LeakyReLU: negative inputs are arithmetically shifted right,
// non-negative inputs (or all inputs when disabled) pass unchanged.
module leaky_relu_act #(
  parameter int DW          = 16,
  parameter int LEAKY_SHIFT = 2,
  parameter int ACT_EN      = 1
) (
  input  logic [DW-1:0] x,
  output logic [DW-1:0] y
);

  logic signed [DW-1:0] xs;
  assign xs = x;

  // Sign-preserving shift keeps the result DW wide, so it cannot overflow.
  always_comb begin
    y = x;
    if ((ACT_EN != 0) && x[DW-1]) y = xs >>> LEAKY_SHIFT;
  end

endmodule

// File: rtl/layer3_input_packer.sv
// Collects N_ELEM activated elements into a flat bus, fires a one-cycle start
// to the layer-3 scorer and holds the bus until done, timeout or abort.
module layer3_input_packer
  import layer3_input_packer_pkg::*;
#(
  parameter int N_ELEM      = N_ELEM_DEF,
  parameter int DW          = DW_DEF,
  parameter int ACT_EN      = 1,
  parameter int LEAKY_SHIFT = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N_ELEM*DW-1:0] flat_out,
  output logic                 l3_start,
  input  logic                 l3_done,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e                       state, state_nx;
  logic [CW-1:0]                cnt;
  logic [TW-1:0]                tmr;
  logic [DW-1:0]                act_data;
  logic [N_ELEM-1:0]            slot_we;
  logic [N_ELEM-1:0][DW-1:0]    slots;
  logic                         accept, last, to_hit;

  leaky_relu_act #(
    .DW          (DW),
    .LEAKY_SHIFT (LEAKY_SHIFT),
    .ACT_EN      (ACT_EN)
  ) u_act (
    .x (in_data),
    .y (act_data)
  );

  // An element presented together with abort is dropped.
  assign accept = (state == ST_FILL) && in_valid && in_ready && !abort;
  assign last   = (cnt == CW'(N_ELEM - 1));
  // tmr counts completed WAIT_DONE cycles, so this is the TIMEOUT_CYC-th cycle.
  assign to_hit = (TIMEOUT_CYC != 0) && (tmr == TW'(TIMEOUT_CYC - 1));
  assign busy   = (state == ST_FIRE) || (state == ST_WAIT_DONE);
  assign flat_out = slots;

  // Next state and pulse outputs; abort overrides everything, done beats timeout.
  always_comb begin
    state_nx    = state;
    l3_start    = 1'b0;
    err_timeout = 1'b0;
    if (abort) begin
      state_nx = ST_FILL;
    end else begin
      case (state)
        ST_FILL:      if (accept && last) state_nx = ST_FIRE;
        ST_FIRE: begin
          l3_start = 1'b1;
          state_nx = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (l3_done) begin
            state_nx = ST_FILL;
          end else if (to_hit) begin
            err_timeout = 1'b1;
            state_nx    = ST_FILL;
          end
        end
        default:      state_nx = ST_FILL;
      endcase
    end
  end

  // State, registered ready, element count and wait timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      in_ready <= 1'b0;
      cnt      <= '0;
      tmr      <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == ST_FILL);
      if (abort)       cnt <= '0;
      else if (accept) cnt <= last ? '0 : cnt + CW'(1);
      if ((state == ST_WAIT_DONE) && (state_nx == ST_WAIT_DONE)) tmr <= tmr + TW'(1);
      else                                                       tmr <= '0;
    end
  end

  // One-hot slot decode for the element being accepted.
  always_comb begin
    slot_we = '0;
    if (accept) slot_we[cnt] = 1'b1;
  end

  // Frame storage; slots are overwritten in place and never cleared between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
    end else begin
      for (int k = 0; k < N_ELEM; k++)
        if (slot_we[k]) slots[k] <= act_data;
    end
  end

endmodule

// File: tb/tb_layer3_input_packer.sv
// Randomized scoreboard bench: a driver updates a behavioural model and queues
// expected frames; a negedge monitor checks handshake/pulse outputs every cycle
// and pops a frame whenever l3_start is seen. Two DUTs share stimulus: one with
// LeakyReLU enabled, one pass-through.
module tb_layer3_input_packer;

  localparam int N  = 32;
  localparam int DW = 16;
  localparam int SH = 2;
  localparam int TO = 64;
  localparam int FW = N * DW;
  localparam int PH_FILL = 0, PH_FIRE = 1, PH_WAIT = 2;

  logic clk, rst, abort, in_valid, l3_done;
  logic [DW-1:0] in_data;
  logic in_ready_a, l3_start_a, busy_a, err_a;
  logic in_ready_p, l3_start_p, busy_p, err_p;
  logic [FW-1:0] flat_a, flat_p;

  layer3_input_packer #(.N_ELEM(N), .DW(DW), .ACT_EN(1), .LEAKY_SHIFT(SH), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .rst(rst), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .flat_out(flat_a), .l3_start(l3_start_a), .l3_done(l3_done),
    .busy(busy_a), .err_timeout(err_a));

  layer3_input_packer #(.N_ELEM(N), .DW(DW), .ACT_EN(0), .LEAKY_SHIFT(SH), .TIMEOUT_CYC(TO)) dut_p (
    .clk(clk), .rst(rst), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_p), .flat_out(flat_p), .l3_start(l3_start_p), .l3_done(l3_done),
    .busy(busy_p), .err_timeout(err_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // model state
  int m_phase, m_cnt, m_wait;
  bit m_ready;
  logic [DW-1:0] fr[N];
  logic [FW-1:0] qa[$], qp[$];
  logic [DW-1:0] pre_q[$];
  logic [DW-1:0] cur;
  bit have;
  bit e_ready, e_busy, e_start, e_err;
  bit mon_en;
  logic [FW-1:0] hold_a, hold_p;
  bit hold_ok;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: cycle bound expired", nm);
  endtask

  // LeakyReLU as floor division by 2^SH for negatives.
  function automatic logic [DW-1:0] leaky(input logic [DW-1:0] x);
    int xi, d, r;
    xi = int'($signed(x));
    if (xi >= 0) return x;
    d = 1 << SH;
    r = (xi - (((xi % d) + d) % d)) / d;
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_elem();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic push_frame();
    logic [FW-1:0] pa, pp;
    for (int k = 0; k < N; k++) begin
      pa[DW*k +: DW] = leaky(fr[k]);
      pp[DW*k +: DW] = fr[k];
    end
    qa.push_back(pa);
    qp.push_back(pp);
    hold_ok = 1'b0;
  endtask

  // One clock cycle: drive inputs, publish expectations, advance the model at the edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit dn, input bit ab);
    in_valid = v; in_data = d; l3_done = dn; abort = ab;
    e_ready = m_ready;
    e_busy  = (m_phase != PH_FILL);
    e_start = (m_phase == PH_FIRE) && !ab;
    e_err   = (m_phase == PH_WAIT) && (m_wait == TO - 1) && !dn && !ab;
    @(posedge clk);
    if (ab) begin
      if (m_phase == PH_FIRE) begin
        void'(qa.pop_back());
        void'(qp.pop_back());
      end
      m_phase = PH_FILL; m_cnt = 0; m_wait = 0; m_ready = 1'b1;
    end else begin
      case (m_phase)
        PH_FILL: begin
          if (v && m_ready) begin
            fr[m_cnt] = d;
            m_cnt++;
            have = 1'b0;
          end
          m_ready = 1'b1;
          if (m_cnt == N) begin
            push_frame();
            m_cnt = 0; m_phase = PH_FIRE; m_ready = 1'b0;
          end
        end
        PH_FIRE: begin m_phase = PH_WAIT; m_wait = 0; end
        default: begin
          if (dn || (m_wait == TO - 1)) begin m_phase = PH_FILL; m_ready = 1'b1; end
          else m_wait++;
        end
      endcase
    end
    #1;
  endtask

  // mode: 0 done after dly wait cycles, 1 never done, 2 done on timeout cycle,
  // 3 abort after dly wait cycles, 4 stop at FIRE, 5 abort in FIRE
  task automatic send_frame(input int gap, input int mode, input int dly);
    int g;
    bit v, dn, ab;
    g = 0;
    while (m_phase == PH_FILL && g < 3000) begin
      if (!have) begin
        cur = (pre_q.size() != 0) ? pre_q.pop_front() : rnd_elem();
        have = 1'b1;
      end
      v = ($urandom_range(0, 99) >= gap);
      cyc(v, cur, 1'b0, 1'b0);
      g++;
    end
    if (m_phase == PH_FILL) begin bound_fail("fill"); return; end
    if (mode == 4) return;
    g = 0;
    while (m_phase != PH_FILL && g < 300) begin
      dn = 1'b0; ab = 1'b0;
      if (m_phase == PH_FIRE) begin
        dn = 1'($urandom_range(0, 1));
        if (mode == 5) ab = 1'b1;
      end else begin
        if (mode == 0 && m_wait == dly) dn = 1'b1;
        if (mode == 2 && m_wait == TO - 1) dn = 1'b1;
        if (mode == 3 && m_wait == dly) ab = 1'b1;
      end
      cyc(1'($urandom_range(0, 1)), rnd_elem(), dn, ab);
      g++;
    end
    if (m_phase != PH_FILL) bound_fail("wait");
  endtask

  task automatic model_reset();
    m_phase = PH_FILL; m_cnt = 0; m_wait = 0; m_ready = 1'b0;
    qa.delete(); qp.delete();
    have = 1'b0; hold_ok = 1'b0;
  endtask

  // Monitor: compare control outputs each cycle, pop and compare frames on start.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready_a, e_ready);
      chk("in_ready_p", in_ready_p, e_ready);
      chk("busy", busy_a, e_busy);
      chk("busy_p", busy_p, e_busy);
      chk("l3_start", l3_start_a, e_start);
      chk("l3_start_p", l3_start_p, e_start);
      chk("err_timeout", err_a, e_err);
      chk("err_timeout_p", err_p, e_err);
      if (l3_start_a) begin
        if (qa.size() == 0) begin
          bound_fail("frame_q_empty");
        end else begin
          hold_a = qa.pop_front();
          hold_p = qp.pop_front();
          hold_ok = 1'b1;
          chk("flat_act", flat_a, hold_a);
          chk("flat_pass", flat_p, hold_p);
        end
      end else if (busy_a && hold_ok) begin
        chk("flat_hold", flat_a, hold_a);
        chk("flat_hold_p", flat_p, hold_p);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    mon_en = 1'b0;
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; l3_done = 1'b0; in_data = '0;
    model_reset();
    #3;
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_flat", flat_a, 0);
    chk("rst_start", l3_start_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_err", err_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);

    // basic frame 1..32, back-to-back
    for (int k = 1; k <= N; k++) pre_q.push_back(16'(k));
    send_frame(0, 0, 3);

    // activation corner values
    pre_q.push_back(16'hFFF0);
    pre_q.push_back(16'h8000);
    send_frame(0, 0, 2);

    // gaps and a slow scorer
    repeat (4) send_frame(30, 0, 20);

    // timeout, then done exactly on the timeout cycle
    send_frame(10, 1, 0);
    send_frame(10, 2, 0);

    // abort after 10 accepts; the next frame needs a full 32
    g = 0;
    while (m_cnt < 10 && g < 500) begin
      if (!have) begin cur = rnd_elem(); have = 1'b1; end
      cyc(1'b1, cur, 1'b0, 1'b0);
      g++;
    end
    if (m_cnt < 10) bound_fail("pre_abort");
    cyc(1'b1, cur, 1'b0, 1'b1);
    send_frame(20, 0, 5);

    // abort in WAIT_DONE, then a late done that must be ignored
    send_frame(0, 3, 5);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // abort in FIRE
    send_frame(10, 5, 0);
    send_frame(10, 0, 1);

    repeat (3) send_frame($urandom_range(0, 50), 0, $urandom_range(0, 30));

    // reset while in FIRE
    send_frame(0, 4, 0);
    mon_en = 1'b0;
    in_valid = 1'b0; l3_done = 1'b0; abort = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_fire_start", l3_start_a, 0);
    chk("rst_fire_busy", busy_a, 0);
    chk("rst_fire_flat", flat_a, 0);
    chk("rst_fire_in_ready", in_ready_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    send_frame(20, 0, 4);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    mon_en = 1'b0;
    chk("frames_left", qa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
